// File: rtl/tbus_mem_responder.sv
// Trinity-bus responder: serves one read/write at a time against a word-addressed array.
// Optional feature macro: TBUS_RESP_RANDLAT_EN adds 0..3 LFSR-chosen wait cycles per request.
`ifndef RESULT_RANGE
`define RESULT_RANGE 63:0
`endif
`ifndef SRC_RANGE
`define SRC_RANGE 63:0
`endif
`ifndef TBUS_OPTYPE_RANGE
`define TBUS_OPTYPE_RANGE 1:0
`endif
`ifndef TBUS_READ
`define TBUS_READ 2'b00
`endif
`ifndef TBUS_WRITE
`define TBUS_WRITE 2'b01
`endif

// Handshake: a request transfers on a rising clock edge where tbus_index_valid and
// tbus_index_ready are both high; ready is high only in IDLE and valid is ignored otherwise.
module tbus_mem_responder #(
    parameter int DEPTH    = 1024,
    parameter int LATENCY  = 1,
    parameter int ADDR_LSB = 3
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      tbus_index_valid,
    output logic                      tbus_index_ready,
    input  logic [`RESULT_RANGE]      tbus_index,
    input  logic [`SRC_RANGE]         tbus_write_data,
    input  logic [63:0]               tbus_write_mask,
    input  logic [`TBUS_OPTYPE_RANGE] tbus_operation_type,
    output logic [`RESULT_RANGE]      tbus_read_data,
    output logic                      tbus_operation_done,
    input  logic                      flush,
    output logic [1:0]                debug_state
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 4) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] count, count_next;
    logic          cancel, cancel_next;
    logic [CW-1:0] wait_cycles;
    logic          accept;

    logic [IW-1:0] idx;
    logic [63:0]   wdata;
    logic [63:0]   wmask;
    logic          is_write;
    logic [63:0]   mem [DEPTH];
    logic          unused_index;

    assign accept       = tbus_index_valid && tbus_index_ready;
    assign unused_index = ^tbus_index;

`ifdef TBUS_RESP_RANDLAT_EN
    logic [7:0] lfsr;

    // Galois form of x^8+x^6+x^5+x^4+1; the low two bits pick the extra wait.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= 8'hA5;
        end else if (accept) begin
            lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
        end
    end

    assign wait_cycles = CW'(LATENCY) + CW'(lfsr[1:0]);
`else
    assign wait_cycles = CW'(LATENCY);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            count  <= '0;
            cancel <= 1'b0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            cancel <= cancel_next;
        end
    end

    always_comb begin
        state_next  = state;
        count_next  = count;
        cancel_next = cancel;
        case (state)
            IDLE: begin
                if (accept) begin
                    cancel_next = 1'b0;
                    if (wait_cycles == '0) begin
                        state_next = RESP;
                    end else begin
                        state_next = BUSY;
                        count_next = wait_cycles - CW'(1);
                    end
                end
            end
            BUSY: begin
                if (flush) begin
                    state_next  = RESP;
                    cancel_next = 1'b1;
                end else if (count == '0) begin
                    state_next = RESP;
                end else begin
                    count_next = count - CW'(1);
                end
            end
            RESP: begin
                state_next  = IDLE;
                cancel_next = 1'b0;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request fields are only consumed while BUSY/RESP, so they need no reset.
    always_ff @(posedge clock) begin
        if (accept) begin
            idx      <= tbus_index[ADDR_LSB +: IW];
            wdata    <= tbus_write_data;
            wmask    <= tbus_write_mask;
            is_write <= (tbus_operation_type == `TBUS_WRITE);
        end
    end

    // A flush arriving during RESP still suppresses the commit.
    always_ff @(posedge clock) begin
        if (state == RESP && is_write && !cancel && !flush) begin
            mem[idx] <= (mem[idx] & ~wmask) | (wdata & wmask);
        end
    end

    assign tbus_index_ready    = (state == IDLE);
    assign tbus_operation_done = (state == RESP);
    assign tbus_read_data      = (state == RESP && !is_write && !cancel) ? mem[idx] : '0;
    assign debug_state         = state;

endmodule
